// File: rtl/mem_access_scheduler_if.sv
// Request, response and memory-port bundle for mem_access_scheduler.
// Handshake: a write or read request transfers on a rising clk edge where valid && ready are both high; ready never depends on valid; the response side has no ready and must be taken when rsp_valid is high.
interface mem_access_scheduler_if;
  logic        wr_valid;
  logic        wr_ready;
  logic [10:0] wr_addr;
  logic [7:0]  wr_data;
  logic        rd_valid;
  logic        rd_ready;
  logic [10:0] rd_addr;
  logic        rsp_valid;
  logic [7:0]  rsp_data;
  logic [10:0] rsp_addr;
  logic        mem_ren;
  logic        mem_wen;
  logic [10:0] mem_raddr;
  logic [10:0] mem_waddr;
  logic [7:0]  mem_din;
  logic [7:0]  mem_dout;

  modport master (
    output wr_valid, wr_addr, wr_data, rd_valid, rd_addr, mem_dout,
    input  wr_ready, rd_ready, rsp_valid, rsp_data, rsp_addr,
           mem_ren, mem_wen, mem_raddr, mem_waddr, mem_din
  );

  modport slave (
    input  wr_valid, wr_addr, wr_data, rd_valid, rd_addr, mem_dout,
    output wr_ready, rd_ready, rsp_valid, rsp_data, rsp_addr,
           mem_ren, mem_wen, mem_raddr, mem_waddr, mem_din
  );
endinterface

// File: rtl/mem_access_scheduler.sv
// Schedules unbuffered reads and FIFO-buffered writes onto a 1R1W memory,
// giving reads priority on same-array conflicts with a starvation-forced write drain.
module mem_access_scheduler #(
  parameter int WR_DEPTH     = 4,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  mem_access_scheduler_if.slave bus,
  output logic                  dbg_drain_o
);
  localparam int PW = $clog2(WR_DEPTH);
  localparam int CW = PW + 1;
  localparam int SW = $clog2(STARVE_LIMIT + 1);

  typedef enum logic {ST_NORMAL, ST_DRAIN} state_e;

  state_e          state_q, state_d;
  logic [10:0]     addr_mem_q [WR_DEPTH];
  logic [7:0]      data_mem_q [WR_DEPTH];
  logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]   count_q, count_d;
  logic [SW-1:0]   stall_q, stall_d;
  logic            rsp_valid_q;
  logic [10:0]     rsp_addr_q;

  logic            empty;
  logic            ren;
  logic            conflict;
  logic            push;
  logic            pop;
  logic [10:0]     head_addr;
  logic [7:0]      head_data;

  assign empty     = (count_q == '0);
  assign head_addr = addr_mem_q[rd_ptr_q];
  assign head_data = data_mem_q[rd_ptr_q];

  // No push-through: a full FIFO refuses writes even when the head pops this cycle.
  assign bus.wr_ready = (count_q < CW'(WR_DEPTH)) && rst_n;
  assign bus.rd_ready = (state_q == ST_NORMAL) && rst_n;

  assign ren      = bus.rd_valid && bus.rd_ready;
  assign conflict = !empty && ren && (head_addr[10:7] == bus.rd_addr[10:7]);
  assign pop      = !empty && !conflict;
  assign push     = bus.wr_valid && bus.wr_ready;

  assign bus.mem_ren   = ren;
  assign bus.mem_raddr = bus.rd_addr;
  assign bus.mem_wen   = pop;
  assign bus.mem_waddr = head_addr;
  assign bus.mem_din   = head_data;

  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_addr  = rsp_addr_q;
  assign bus.rsp_data  = bus.mem_dout;

  assign dbg_drain_o = (state_q == ST_DRAIN);

  always_comb begin
    wr_ptr_d = wr_ptr_q + PW'(push);
    rd_ptr_d = rd_ptr_q + PW'(pop);
    count_d  = count_q + CW'(push) - CW'(pop);
    stall_d  = '0;
    state_d  = state_q;

    if (conflict) begin
      stall_d = (stall_q == SW'(STARVE_LIMIT)) ? stall_q : stall_q + SW'(1);
    end

    // Entering DRAIN as the count reaches the limit blocks reads on the very next cycle.
    case (state_q)
      ST_NORMAL: if (stall_d == SW'(STARVE_LIMIT)) state_d = ST_DRAIN;
      ST_DRAIN:  state_d = ST_NORMAL;
      default:   state_d = ST_NORMAL;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_NORMAL;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      stall_q     <= '0;
      rsp_valid_q <= 1'b0;
      rsp_addr_q  <= '0;
    end else begin
      state_q     <= state_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      stall_q     <= stall_d;
      rsp_valid_q <= ren;
      rsp_addr_q  <= bus.mem_raddr;
    end
  end

  // Entry storage needs no reset; occupancy is governed by count_q.
  always_ff @(posedge clk) begin
    if (push) begin
      addr_mem_q[wr_ptr_q] <= bus.wr_addr;
      data_mem_q[wr_ptr_q] <= bus.wr_data;
    end
  end
endmodule
